// File: rtl/render_pkg.sv
// Shared definitions for the frame sequencer and the pixel renderer.
package render_pkg;

  localparam logic [2:0] VIEW_FRONT = 3'b001;
  localparam logic [2:0] VIEW_RIGHT = 3'b110;
  localparam logic [2:0] VIEW_LEFT  = 3'b011;

  localparam int unsigned FRAME_LINE_DEF = 515;

  typedef enum logic [2:0] {
    GUN_IDLE    = 3'd0,
    GUN_SHOOT1  = 3'd1,
    GUN_SHOOT2  = 3'd2,
    GUN_RELOAD1 = 3'd3,
    GUN_RELOAD2 = 3'd4,
    GUN_RELOAD3 = 3'd5,
    GUN_RELOAD4 = 3'd6
  } gun_frame_t;

  // Only the three camera codes are meaningful; anything else is a glitch to ignore.
  function automatic logic view_legal(input logic [2:0] v);
    return (v == VIEW_FRONT) || (v == VIEW_RIGHT) || (v == VIEW_LEFT);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-clk frame boundary pulse. The scan counters hold each value for
// several clk, so the boundary compare is edge-detected against its own
// registered copy.
module frame_tick_gen
  import render_pkg::*;
#(
  parameter int unsigned FRAME_LINE = FRAME_LINE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       frame_tick
);

  logic tick_cond;
  logic tick_cond_d;

  assign tick_cond  = (vCount == 10'(FRAME_LINE)) && (hCount == 10'd0);
  assign frame_tick = tick_cond & ~tick_cond_d;

  // Remember last clk's boundary compare for the rising-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cond_d <= 1'b0;
    else          tick_cond_d <= tick_cond;
  end

endmodule

// File: rtl/render_frame_sequencer.sv
// Frame-synchronous game controller: latches view/enemy state, run state and
// the weapon sprite animation only on the vertical-blank frame boundary.
//
// gun state   | meaning
// ------------+---------------------------------------------
// GUN_IDLE    | weapon at rest; a pending fire starts SHOOT1
// GUN_SHOOT1  | first muzzle frame, held SHOOT_FRAMES frames
// GUN_SHOOT2  | second muzzle frame, held SHOOT_FRAMES frames
// GUN_RELOAD1 | reload frames 1..4, each held RELOAD_FRAMES
// ..RELOAD4   | frames, then back to GUN_IDLE
module render_frame_sequencer
  import render_pkg::*;
#(
  parameter int unsigned FRAME_LINE    = FRAME_LINE_DEF,
  parameter int unsigned SHOOT_FRAMES  = 4,
  parameter int unsigned RELOAD_FRAMES = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       start_pulse,
  input  logic       game_over,
  input  logic       fire_req,
  input  logic [2:0] camera_view,
  input  logic       forward_enemy_flag,
  input  logic       right_enemy_flag,
  input  logic       left_enemy_flag,
  output logic       frame_tick,
  output logic       running,
  output logic       title_en,
  output logic [2:0] view_q,
  output logic       enemy_vis_q,
  output logic [2:0] gun_frame,
  output logic       gun_busy,
  output logic       shot_fired,
  output logic       fire_reject
);

  localparam logic [5:0] SHOOT_LOAD  = 6'(SHOOT_FRAMES - 1);
  localparam logic [5:0] RELOAD_LOAD = 6'(RELOAD_FRAMES - 1);

  gun_frame_t gun_state;
  gun_frame_t gun_next;
  logic [5:0] step_cnt;
  logic [5:0] step_load;
  logic       pending;
  logic       start_pend;
  logic       go_pend;
  logic       go_now;
  logic [2:0] view_nxt;
  logic       enemy_nxt;

  frame_tick_gen #(.FRAME_LINE(FRAME_LINE)) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .hCount     (hCount),
    .vCount     (vCount),
    .frame_tick (frame_tick)
  );

  assign gun_frame = gun_state;
  assign title_en  = ~running;
  assign gun_busy  = (gun_state != GUN_IDLE) | pending;
  // A game_over landing on the tick clk itself is honoured at that tick.
  assign go_now    = go_pend | game_over;

  // View to latch at the boundary and the enemy flag belonging to it.
  always_comb begin
    view_nxt  = view_legal(camera_view) ? camera_view : view_q;
    enemy_nxt = 1'b0;
    case (view_nxt)
      VIEW_FRONT: enemy_nxt = forward_enemy_flag;
      VIEW_RIGHT: enemy_nxt = right_enemy_flag;
      VIEW_LEFT:  enemy_nxt = left_enemy_flag;
      default:    enemy_nxt = 1'b0;
    endcase
  end

  // Animation step order and the hold count for the step being entered.
  always_comb begin
    gun_next  = GUN_IDLE;
    step_load = 6'd0;
    case (gun_state)
      GUN_SHOOT1:  begin gun_next = GUN_SHOOT2;  step_load = SHOOT_LOAD;  end
      GUN_SHOOT2:  begin gun_next = GUN_RELOAD1; step_load = RELOAD_LOAD; end
      GUN_RELOAD1: begin gun_next = GUN_RELOAD2; step_load = RELOAD_LOAD; end
      GUN_RELOAD2: begin gun_next = GUN_RELOAD3; step_load = RELOAD_LOAD; end
      GUN_RELOAD3: begin gun_next = GUN_RELOAD4; step_load = RELOAD_LOAD; end
      default:     begin gun_next = GUN_IDLE;    step_load = 6'd0;        end
    endcase
  end

  // Run control, fire capture and gun animation; state moves only on frame_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running     <= 1'b0;
      start_pend  <= 1'b0;
      go_pend     <= 1'b0;
      pending     <= 1'b0;
      gun_state   <= GUN_IDLE;
      step_cnt    <= 6'd0;
      view_q      <= VIEW_FRONT;
      enemy_vis_q <= 1'b0;
      shot_fired  <= 1'b0;
      fire_reject <= 1'b0;
    end else begin
      shot_fired  <= 1'b0;
      fire_reject <= 1'b0;
      if (game_over) go_pend <= 1'b1;
      if (start_pulse && !running) start_pend <= 1'b1;
      if (fire_req && running) begin
        if (gun_state == GUN_IDLE && !pending) pending <= 1'b1;
        else                                   fire_reject <= 1'b1;
      end
      if (frame_tick) begin
        view_q      <= view_nxt;
        enemy_vis_q <= enemy_nxt;
        if (go_now) begin
          running    <= 1'b0;
          gun_state  <= GUN_IDLE;
          step_cnt   <= 6'd0;
          pending    <= 1'b0;
          start_pend <= 1'b0;
          go_pend    <= 1'b0;
        end else begin
          if (start_pend) begin
            running    <= 1'b1;
            start_pend <= 1'b0;
          end
          if (gun_state == GUN_IDLE) begin
            if (pending) begin
              gun_state  <= GUN_SHOOT1;
              pending    <= 1'b0;
              step_cnt   <= SHOOT_LOAD;
              shot_fired <= 1'b1;
            end
          end else if (step_cnt != 6'd0) begin
            step_cnt <= step_cnt - 6'd1;
          end else begin
            gun_state <= gun_next;
            step_cnt  <= step_load;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Directed bench for render_frame_sequencer using short synthetic frames.
module tb_render_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hCount, vCount;
  logic       start_pulse, game_over, fire_req;
  logic [2:0] camera_view;
  logic       forward_enemy_flag, right_enemy_flag, left_enemy_flag;
  logic       frame_tick, running, title_en, enemy_vis_q, gun_busy, shot_fired, fire_reject;
  logic [2:0] view_q, gun_frame;

  int tests = 0;
  int failed = 0;
  int ticks = 0;
  int shots = 0;
  int rejects = 0;

  typedef struct {
    logic [2:0] cam;
    logic       f, r, l;
    logic [2:0] exp_view;
    logic       exp_vis;
  } view_vec_t;

  view_vec_t vtab [6];

  render_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .hCount(hCount), .vCount(vCount),
    .start_pulse(start_pulse), .game_over(game_over), .fire_req(fire_req),
    .camera_view(camera_view), .forward_enemy_flag(forward_enemy_flag),
    .right_enemy_flag(right_enemy_flag), .left_enemy_flag(left_enemy_flag),
    .frame_tick(frame_tick), .running(running), .title_en(title_en),
    .view_q(view_q), .enemy_vis_q(enemy_vis_q), .gun_frame(gun_frame),
    .gun_busy(gun_busy), .shot_fired(shot_fired), .fire_reject(fire_reject)
  );

  always #5 clk = ~clk;

  // Registered pulses are stable at the falling edge; count them there.
  always @(negedge clk) begin
    if (reset_n) begin
      if (shot_fired)  shots++;
      if (fire_reject) rejects++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Short frame: boundary line held 4 clk, then 4 clk of visible scan.
  task automatic frame(input logic fire_on_tick = 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vCount = 10'd515; hCount = 10'd0;
      fire_req = (i == 0) ? fire_on_tick : 1'b0;
      #1 if (frame_tick) ticks++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vCount = 10'd10; hCount = 10'(i); fire_req = 1'b0;
      #1 if (frame_tick) ticks++;
    end
    wait_clks(1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start_pulse = 1'b1;
    @(negedge clk); start_pulse = 1'b0;
  endtask

  task automatic pulse_fire();
    @(negedge clk); fire_req = 1'b1;
    @(negedge clk); fire_req = 1'b0;
  endtask

  task automatic pulse_over();
    @(negedge clk); game_over = 1'b1;
    @(negedge clk); game_over = 1'b0;
  endtask

  function automatic int exp_gun(input int idx);
    if (idx < 4)  return 1;
    if (idx < 8)  return 2;
    if (idx < 32) return 3 + (idx - 8) / 6;
    return 0;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " running"}, running, 0);
    chk({tag, " title_en"}, title_en, 1);
    chk({tag, " view_q"}, view_q, 1);
    chk({tag, " enemy_vis_q"}, enemy_vis_q, 0);
    chk({tag, " gun_frame"}, gun_frame, 0);
    chk({tag, " gun_busy"}, gun_busy, 0);
    chk({tag, " shot_fired"}, shot_fired, 0);
    chk({tag, " fire_reject"}, fire_reject, 0);
  endtask

  initial begin
    vtab[0] = '{3'b110, 1'b0, 1'b1, 1'b0, 3'b110, 1'b1};
    vtab[1] = '{3'b111, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0};
    vtab[2] = '{3'b011, 1'b0, 1'b1, 1'b1, 3'b011, 1'b1};
    vtab[3] = '{3'b001, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0};
    vtab[4] = '{3'b000, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1};
    vtab[5] = '{3'b110, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0};

    reset_n = 1'b0; hCount = 10'd0; vCount = 10'd10;
    start_pulse = 1'b0; game_over = 1'b0; fire_req = 1'b0;
    camera_view = 3'b001;
    forward_enemy_flag = 1'b0; right_enemy_flag = 1'b0; left_enemy_flag = 1'b0;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(2);
    chk_reset_outputs("reset");

    // Idle scanning: one single-clk tick per frame, title stays up.
    ticks = 0;
    repeat (3) frame();
    chk("tick count 3 frames", ticks, 3);
    chk("idle title_en", title_en, 1);
    chk("idle gun_frame", gun_frame, 0);
    chk("idle view_q", view_q, 1);

    // Start waits for the boundary; a repeat start changes nothing.
    pulse_start();
    wait_clks(2);
    chk("start mid-frame running", running, 0);
    frame();
    chk("start running", running, 1);
    chk("start title_en", title_en, 0);
    pulse_start();
    frame();
    chk("second start running", running, 1);

    // View / enemy latching table.
    for (int i = 0; i < 6; i++) begin
      logic [2:0] pv;
      logic       pe;
      pv = view_q; pe = enemy_vis_q;
      @(negedge clk);
      camera_view = vtab[i].cam;
      forward_enemy_flag = vtab[i].f;
      right_enemy_flag = vtab[i].r;
      left_enemy_flag = vtab[i].l;
      wait_clks(2);
      chk($sformatf("vec%0d view held mid-frame", i), view_q, (i == 0) ? 1 : vtab[i-1].exp_view);
      chk($sformatf("vec%0d enemy held mid-frame", i), enemy_vis_q, (i == 0) ? 0 : vtab[i-1].exp_vis);
      frame();
      chk($sformatf("vec%0d view_q", i), view_q, vtab[i].exp_view);
      chk($sformatf("vec%0d enemy_vis_q", i), enemy_vis_q, vtab[i].exp_vis);
    end

    // Full animation, with a rejected fire during RELOAD1.
    shots = 0; rejects = 0;
    pulse_fire();
    wait_clks(1);
    chk("fire pending busy", gun_busy, 1);
    chk("fire pending gun_frame", gun_frame, 0);
    for (int n = 0; n <= 32; n++) begin
      frame();
      chk($sformatf("anim idx%0d gun_frame", n), gun_frame, exp_gun(n));
      if (n == 8) begin
        pulse_fire();
        wait_clks(3);
        chk("reject pulse count", rejects, 1);
      end
    end
    chk("anim shot count", shots, 1);
    chk("anim end busy", gun_busy, 0);

    // Fire landing on the tick clk is served one frame later.
    frame(1'b1);
    chk("tick fire gun_frame", gun_frame, 0);
    chk("tick fire busy", gun_busy, 1);
    frame();
    chk("tick fire SHOOT1", gun_frame, 1);
    chk("tick fire shot count", shots, 2);

    // Game over during RELOAD2.
    repeat (14) frame();
    chk("pre-over gun_frame", gun_frame, 4);
    pulse_over();
    wait_clks(1);
    chk("over mid-frame running", running, 1);
    chk("over mid-frame gun_frame", gun_frame, 4);
    frame();
    chk("over running", running, 0);
    chk("over gun_frame", gun_frame, 0);
    chk("over title_en", title_en, 1);
    chk("over busy", gun_busy, 0);

    // Start and game_over before the same tick: game_over wins.
    @(negedge clk); start_pulse = 1'b1; game_over = 1'b1;
    @(negedge clk); start_pulse = 1'b0; game_over = 1'b0;
    frame();
    chk("coincide running", running, 0);
    frame();
    chk("coincide running later", running, 0);

    // Asynchronous reset in the middle of an animation.
    right_enemy_flag = 1'b1;
    pulse_start();
    frame();
    chk("restart running", running, 1);
    pulse_fire();
    repeat (3) frame();
    chk("pre-reset gun_frame", gun_frame, 1);
    chk("pre-reset view_q", view_q, 6);
    chk("pre-reset enemy_vis_q", enemy_vis_q, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    wait_clks(2);
    reset_n = 1'b1;
    wait_clks(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/render_frame_sequencer.md
Name: render_frame_sequencer

Overview:
- Frame-synchronous controller placed in front of the pixel renderer's priority mux.
- Latches game state only at a vertical-blank frame boundary, so no frame shows a mid-frame change (no tearing).
- Sequences the weapon sprite animation: idle, 2 shoot frames, 4 reload frames.
- Gates the title screen with start and game-over events.

Parameters:
- FRAME_LINE, 515: vCount value marking the frame boundary (first blank line).
- SHOOT_FRAMES, 4: video frames held on each shoot step (1..63).
- RELOAD_FRAMES, 6: video frames held on each reload step (1..63).

Ports:
- clk  in  1  system clock (100 MHz; hCount/vCount advance every 4 clk).
- reset_n  in  1  asynchronous, active-low reset.
- hCount  in  10  current scan column.
- vCount  in  10  current scan line.
- start_pulse  in  1  one-clk start-game pulse (synchronised upstream).
- game_over  in  1  one-clk pulse; returns the game to the title screen.
- fire_req  in  1  one-clk fire request.
- camera_view  in  3  live view code: 001 front, 110 right, 011 left.
- forward_enemy_flag, right_enemy_flag, left_enemy_flag  in  1 each  live enemy presence.
- frame_tick  out  1  one-clk pulse at the frame boundary.
- running  out  1  game active; reset 0.
- title_en  out  1  equals ~running; reset 1.
- view_q  out  3  frame-stable view code; reset 001.
- enemy_vis_q  out  1  frame-stable "enemy in current view"; reset 0.
- gun_frame  out  3  sprite select: 0 IDLE, 1 SHOOT1, 2 SHOOT2, 3..6 RELOAD1..4; reset 0.
- gun_busy  out  1  high whenever gun_frame != 0 or a fire is pending; reset 0.
- shot_fired  out  1  one-clk pulse on entry to SHOOT1; reset 0.
- fire_reject  out  1  one-clk pulse when a fire_req is dropped; reset 0.

Behaviour:
- Asynchronous reset clears every register to the values listed above, plus internal state: pending=0, step_cnt=0, tick_cond_d=0.
- Frame tick
  - tick_cond = (vCount==FRAME_LINE && hCount==0), registered into tick_cond_d.
  - frame_tick = tick_cond & ~tick_cond_d. This gives exactly one pulse per frame even though the counters hold for 4 clk.
  - frame_tick is combinational from a registered term plus the inputs.
- Latching (on frame_tick only)
  - view_q <= camera_view if the code is one of 001/110/011; any other code holds the previous view_q.
  - enemy_vis_q <= flag selected by the new view_q value.
- Run control
  - start_pulse while !running sets start_pend; start_pulse while running is ignored.
  - On frame_tick with start_pend: running<=1, start_pend<=0.
  - game_over is acted on at the next frame_tick: running<=0, gun_frame<=0, step_cnt<=0, pending<=0, start_pend<=0.
  - If game_over and start_pend coincide at the same tick, game_over wins.
- Fire capture (any clk)
  - If running && gun_frame==0 && !pending: pending<=1.
  - Else if running: fire_reject pulses next clk, pending is unchanged.
  - If !running: silently ignored.
  - fire_req coinciding with frame_tick while idle: captured, then consumed at the following frame_tick (one-frame latency, deterministic).
- Gun FSM (advances only on frame_tick)
  - IDLE with pending: go to SHOOT1, pending<=0, step_cnt<=SHOOT_FRAMES-1, shot_fired pulses the same clk as the transition.
  - In any other state: if step_cnt!=0, decrement it; else advance SHOOT1→SHOOT2→RELOAD1→…→RELOAD4→IDLE.
  - On each advance, load step_cnt with (SHOOT_FRAMES or RELOAD_FRAMES)-1 according to the new state.
  - Total busy span: 2·SHOOT_FRAMES + 4·RELOAD_FRAMES frames. Defaults: 32 frames.
  - step_cnt is 6 bits and cannot wrap, given the legal parameter range.
- All outputs except frame_tick are registered and change only on a clk edge.
- A reset asserted mid-animation returns to IDLE/title immediately and asynchronously.

Decomposition:
- Shared package render_pkg holds:
  - view codes VIEW_FRONT=3'b001, VIEW_RIGHT=3'b110, VIEW_LEFT=3'b011;
  - gun frame codes GUN_IDLE..GUN_RELOAD4;
  - default FRAME_LINE.
- The renderer uses the same package.
- One sub-module, frame_tick_gen: the tick_cond compare, edge detect and FRAME_LINE parameter.

Test Plan:
1. Reset, then scan 3 frames with no inputs → title_en=1, gun_frame=0, view_q=001, exactly 3 frame_tick pulses, each 1 clk wide.
2. start_pulse mid-frame → running stays 0 until the next frame_tick, then running=1 and title_en=0. A second start_pulse has no effect.
3. Running, fire_req while idle → at the next tick gun_frame=1 and shot_fired pulses once. Then gun_frame holds 1 for 4 frames, 2 for 4, each of 3..6 for 6 frames, and returns to 0 after exactly 32 ticks.
4. fire_req during gun_frame=3 → fire_reject pulses one clk later and the sequence is unchanged. fire_req coincident with frame_tick while idle → SHOOT1 begins one tick later.
5. camera_view changes 001→110 mid-frame with right_enemy_flag=1 → view_q and enemy_vis_q unchanged until the tick, then 110 and 1. Illegal code 111 → view_q holds 110.
6. game_over during gun_frame=4 → at the next tick running=0, gun_frame=0, title_en=1. reset_n pulsed low mid-frame → all outputs return to reset values without a clk edge.
